polaris_bus_arbiter: RTL and testbench

POLARIS_BUS_ARBITER -- requirements
Module: polaris_bus_arbiter

---
 rtl/polaris_pkg.sv | 14 +
 rtl/polaris_bus_watchdog.sv | 38 +++
 rtl/polaris_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_polaris_bus_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polaris_pkg.sv
// Shared definitions for the Polaris CPU bus arbiter: grant encoding and bus
// size constants.
package polaris_pkg;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'b00,
      GNT_I    = 2'b01,
      GNT_D    = 2'b10
   } grant_e;

   localparam logic [1:0] BSIZ_WORD = 2'b10;
   localparam int         WAIT_W    = 8;

endpackage

// File: rtl/polaris_bus_watchdog.sv
// Wait-state counter for the granted transfer. It signals expiry once the
// strobe has gone unanswered for TIMEOUT_CYCLES cycles.
module polaris_bus_watchdog
   import polaris_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic wait_i,
   output logic expire_o
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   assign expire_o = wait_i && (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (wait_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/polaris_bus_arbiter.sv
// Two-master arbiter (instruction fetch and data) onto one shared memory bus.
// Data wins ties and keeps the bus locked for the whole dcyc_i cycle.
module polaris_bus_arbiter
   import polaris_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        istb_i,
   input  logic [63:0] iadr_i,
   output logic        iack_o,
   output logic [31:0] idat_o,
   input  logic        dcyc_i,
   input  logic        dstb_i,
   input  logic        dwe_i,
   input  logic [63:0] dadr_i,
   input  logic [63:0] ddat_i,
   input  logic [1:0]  dsiz_i,
   input  logic        dsigned_i,
   output logic        dack_o,
   output logic [63:0] ddat_o,
   output logic        bcyc_o,
   output logic        bstb_o,
   output logic        bwe_o,
   output logic        bsigned_o,
   output logic [63:0] badr_o,
   output logic [63:0] bdat_o,
   output logic [1:0]  bsiz_o,
   input  logic        back_i,
   input  logic [63:0] bdat_i,
   output logic        timeout_o,
   output logic [1:0]  gnt_o
);

   grant_e state_q, state_d;
   logic   expire;
   logic   iack_bus, dack_bus;
   logic   wd_clr;

   always_comb begin
      bcyc_o    = 1'b0;
      bstb_o    = 1'b0;
      bwe_o     = 1'b0;
      bsigned_o = 1'b0;
      badr_o    = '0;
      bdat_o    = '0;
      bsiz_o    = '0;
      case (state_q)
         GNT_I: begin
            bcyc_o = istb_i;
            bstb_o = istb_i;
            badr_o = iadr_i;
            bsiz_o = BSIZ_WORD;
         end
         GNT_D: begin
            bcyc_o    = dcyc_i;
            bstb_o    = dstb_i;
            bwe_o     = dwe_i;
            bsigned_o = dsigned_i;
            badr_o    = dadr_i;
            bdat_o    = ddat_i;
            bsiz_o    = dsiz_i;
         end
         default: ;
      endcase
   end

   // Read data only passes through on a real slave ack, never on a forced one.
   assign iack_bus  = (state_q == GNT_I) && istb_i && back_i;
   assign dack_bus  = (state_q == GNT_D) && dstb_i && back_i;
   assign iack_o    = (state_q == GNT_I) && istb_i && (back_i || expire);
   assign dack_o    = (state_q == GNT_D) && dstb_i && (back_i || expire);
   assign idat_o    = iack_bus ? bdat_i[31:0] : '0;
   assign ddat_o    = dack_bus ? bdat_i : '0;
   assign timeout_o = expire;
   assign gnt_o     = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         GNT_IDLE: begin
            if (dcyc_i)      state_d = GNT_D;
            else if (istb_i) state_d = GNT_I;
         end
         GNT_I: begin
            if (iack_o || !istb_i) begin
               if (dcyc_i)      state_d = GNT_D;
               else if (istb_i) state_d = GNT_I;
               else             state_d = GNT_IDLE;
            end
         end
         GNT_D: begin
            if (!dcyc_i) begin
               state_d = istb_i ? GNT_I : GNT_IDLE;
            end
         end
         default: state_d = GNT_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= GNT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign wd_clr = (state_d != state_q) || iack_o || dack_o || !bstb_o;

   polaris_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (wd_clr),
      .wait_i   (bstb_o && !back_i),
      .expire_o (expire)
   );

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level owner/wait model.
module tb_polaris_bus_arbiter;
   localparam int TO = 4;

   logic        clk_i, reset_i;
   logic        istb_i;
   logic [63:0] iadr_i;
   logic        iack_o;
   logic [31:0] idat_o;
   logic        dcyc_i, dstb_i, dwe_i, dsigned_i;
   logic [63:0] dadr_i, ddat_i;
   logic [1:0]  dsiz_i;
   logic        dack_o;
   logic [63:0] ddat_o;
   logic        bcyc_o, bstb_o, bwe_o, bsigned_o;
   logic [63:0] badr_o, bdat_o;
   logic [1:0]  bsiz_o;
   logic        back_i;
   logic [63:0] bdat_i;
   logic        timeout_o;
   logic [1:0]  gnt_o;

   int errors = 0;
   int checks = 0;

   polaris_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .istb_i(istb_i), .iadr_i(iadr_i), .iack_o(iack_o), .idat_o(idat_o),
      .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dadr_i(dadr_i),
      .ddat_i(ddat_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
      .dack_o(dack_o), .ddat_o(ddat_o),
      .bcyc_o(bcyc_o), .bstb_o(bstb_o), .bwe_o(bwe_o), .bsigned_o(bsigned_o),
      .badr_o(badr_o), .bdat_o(bdat_o), .bsiz_o(bsiz_o),
      .back_i(back_i), .bdat_i(bdat_i),
      .timeout_o(timeout_o), .gnt_o(gnt_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_all();
      istb_i = 0; dcyc_i = 0; dstb_i = 0; dwe_i = 0; dsigned_i = 0;
      iadr_i = '0; dadr_i = '0; ddat_i = '0; dsiz_i = '0;
      back_i = 0; bdat_i = '0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      logic [255:0] all_out;
      reset_i = 0;
      idle_all();
      istb_i = 1; dcyc_i = 1; dstb_i = 1; back_i = 1; bdat_i = 64'hFFFF;
      tick();
      #2;
      all_out = 256'({gnt_o, bcyc_o, bstb_o, bwe_o, bsigned_o, bsiz_o, badr_o, bdat_o,
                      iack_o, dack_o, idat_o, ddat_o, timeout_o});
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      reset_i = 1;
      tick();
      #2;
      checks++;
      if (gnt_o !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_grant: got %b want 10", gnt_o);
      end
      idle_all();
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_return_idle: got %b want 00", gnt_o);
      end
   endtask

   task automatic test_ifetch();
      istb_i = 1; iadr_i = 64'h1000; back_i = 0;
      #2;
      checks++;
      if ({gnt_o, bstb_o} !== 3'b000) begin
         errors++;
         $display("FAIL ifetch_idle: got gnt=%b bstb=%b want 00/0", gnt_o, bstb_o);
      end
      tick();
      #2;
      checks++;
      if ({gnt_o, badr_o, bsiz_o, bstb_o, iack_o} !== {2'b01, 64'h1000, 2'b10, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL ifetch_grant: got gnt=%b badr=%h bsiz=%b bstb=%b iack=%b want 01/1000/10/1/0",
                  gnt_o, badr_o, bsiz_o, bstb_o, iack_o);
      end
      back_i = 1; bdat_i = 64'hDEADBEEF_00000013;
      #2;
      checks++;
      if ({iack_o, idat_o, dack_o} !== {1'b1, 32'h00000013, 1'b0}) begin
         errors++;
         $display("FAIL ifetch_ack: got iack=%b idat=%h dack=%b want 1/00000013/0",
                  iack_o, idat_o, dack_o);
      end
      tick();
      istb_i = 0; back_i = 0;
      tick();
      #2;
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++;
         $display("FAIL ifetch_release: got %b want 00", gnt_o);
      end
      idle_all();
   endtask

   task automatic test_simultaneous();
      istb_i = 1; iadr_i = 64'h2000; dcyc_i = 1; dstb_i = 1; dadr_i = 64'h3000; back_i = 0;
      tick();
      #2;
      checks++;
      if ({gnt_o, badr_o} !== {2'b10, 64'h3000}) begin
         errors++;
         $display("FAIL simul_d_first: got gnt=%b badr=%h want 10/3000", gnt_o, badr_o);
      end
      back_i = 1;
      #2;
      checks++;
      if ({iack_o, dack_o} !== 2'b01) begin
         errors++;
         $display("FAIL simul_d_ack: got iack=%b dack=%b want 0/1", iack_o, dack_o);
      end
      tick();
      dcyc_i = 0; dstb_i = 0; back_i = 0;
      tick();
      #2;
      checks++;
      if ({gnt_o, bstb_o, badr_o} !== {2'b01, 1'b1, 64'h2000}) begin
         errors++;
         $display("FAIL simul_i_next: got gnt=%b bstb=%b badr=%h want 01/1/2000", gnt_o, bstb_o, badr_o);
      end
      back_i = 1;
      #2;
      checks++;
      if ({iack_o, dack_o} !== 2'b10) begin
         errors++;
         $display("FAIL simul_i_ack: got iack=%b dack=%b want 1/0", iack_o, dack_o);
      end
      idle_all();
   endtask

   task automatic test_locked_burst();
      istb_i = 1; iadr_i = 64'h4000;
      dcyc_i = 1; dstb_i = 1; dwe_i = 1; ddat_i = 64'h55; back_i = 0;
      tick();
      back_i = 1;
      #2;
      checks++;
      if ({gnt_o, bwe_o, bdat_o, dack_o} !== {2'b10, 1'b1, 64'h55, 1'b1}) begin
         errors++;
         $display("FAIL burst_beat1: got gnt=%b bwe=%b bdat=%h dack=%b want 10/1/55/1",
                  gnt_o, bwe_o, bdat_o, dack_o);
      end
      tick();
      ddat_i = 64'hAA;
      #2;
      checks++;
      if ({gnt_o, bdat_o, dack_o, iack_o} !== {2'b10, 64'hAA, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL burst_beat2: got gnt=%b bdat=%h dack=%b iack=%b want 10/aa/1/0",
                  gnt_o, bdat_o, dack_o, iack_o);
      end
      tick();
      dcyc_i = 0; dstb_i = 0; dwe_i = 0; back_i = 0;
      tick();
      #2;
      checks++;
      if ({gnt_o, badr_o, bwe_o} !== {2'b01, 64'h4000, 1'b0}) begin
         errors++;
         $display("FAIL burst_then_i: got gnt=%b badr=%h bwe=%b want 01/4000/0", gnt_o, badr_o, bwe_o);
      end
      idle_all();
   endtask

   task automatic test_timeout();
      dcyc_i = 1; dstb_i = 1; dwe_i = 0; dadr_i = 64'h5000; back_i = 0;
      bdat_i = 64'h1234_5678_9ABC_DEF0;
      tick();
      for (int k = 1; k <= 6; k++) begin
         #2;
         checks++;
         if ({dack_o, timeout_o, ddat_o} !== {(k == 5), (k == 5), 64'h0}) begin
            errors++;
            $display("FAIL timeout_cycle%0d: got dack=%b timeout=%b ddat=%h want %0d/%0d/0",
                     k, dack_o, timeout_o, ddat_o, (k == 5), (k == 5));
         end
         tick();
      end
      dcyc_i = 0; dstb_i = 0;
      tick();
      #2;
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++;
         $display("FAIL timeout_release: got %b want 00", gnt_o);
      end
      idle_all();
   endtask

   task automatic test_reset_mid();
      istb_i = 1; iadr_i = 64'h6000; back_i = 0;
      tick();
      #2;
      checks++;
      if ({gnt_o, bstb_o} !== 3'b011) begin
         errors++;
         $display("FAIL rstmid_pending: got gnt=%b bstb=%b want 01/1", gnt_o, bstb_o);
      end
      reset_i = 0;
      back_i = 1;
      #1;
      checks++;
      if ({gnt_o, bstb_o, bcyc_o, badr_o, iack_o, idat_o} !== '0) begin
         errors++;
         $display("FAIL rstmid_immediate: got gnt=%b bstb=%b badr=%h iack=%b want all 0",
                  gnt_o, bstb_o, badr_o, iack_o);
      end
      tick();
      reset_i = 1;
      back_i = 0;
      #2;
      checks++;
      if (gnt_o !== 2'b00) begin
         errors++;
         $display("FAIL rstmid_before_edge: got %b want 00", gnt_o);
      end
      tick();
      #2;
      checks++;
      if ({gnt_o, bstb_o} !== 3'b011) begin
         errors++;
         $display("FAIL rstmid_regrant: got gnt=%b bstb=%b want 01/1", gnt_o, bstb_o);
      end
      idle_all();
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      istb_i = 1; back_i = 1; iadr_i = 64'h7000;
      #2;
      checks++;
      if (iack_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_ignored: got iack=%b want 0", iack_o);
      end
      tick();
      for (int k = 0; k < 8; k++) begin
         iadr_i = {$urandom, $urandom};
         bdat_i = {$urandom, $urandom};
         #2;
         checks++;
         if ({gnt_o, iack_o, idat_o, badr_o} !== {2'b01, 1'b1, bdat_i[31:0], iadr_i}) begin
            errors++;
            $display("FAIL b2b_beat%0d: got gnt=%b iack=%b idat=%h badr=%h want 01/1/%h/%h",
                     k, gnt_o, iack_o, idat_o, badr_o, bdat_i[31:0], iadr_i);
         end
         if (iack_o === 1'b1) acks++;
         tick();
      end
      checks++;
      if (acks != 8) begin
         errors++;
         $display("FAIL b2b_ack_count: got %0d want 8", acks);
      end
      idle_all();
   endtask

   function automatic int arbitrate(logic dcyc, logic istb);
      if (dcyc) return 2;
      if (istb) return 1;
      return 0;
   endfunction

   task automatic test_random();
      int own = 0;
      int wt = 0;
      int nown;
      logic e_cyc, e_stb, e_we, e_sgn, e_exp, e_iack, e_dack;
      logic [1:0] e_siz;
      logic [63:0] e_adr, e_dat, e_ddat;
      logic [31:0] e_idat;
      idle_all();
      for (int n = 0; n < 600; n++) begin
         istb_i = ($urandom_range(0, 3) != 0);
         dcyc_i = dcyc_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         dstb_i = ($urandom_range(0, 2) != 0);
         dwe_i = 1'($urandom); dsigned_i = 1'($urandom); dsiz_i = 2'($urandom);
         iadr_i = {$urandom, $urandom}; dadr_i = {$urandom, $urandom};
         ddat_i = {$urandom, $urandom}; bdat_i = {$urandom, $urandom};
         back_i = ($urandom_range(0, 2) == 0);
         #2;
         {e_cyc, e_stb, e_we, e_sgn, e_siz, e_adr, e_dat} = '0;
         if (own == 1) begin
            {e_cyc, e_stb, e_siz, e_adr} = {istb_i, istb_i, 2'b10, iadr_i};
         end else if (own == 2) begin
            {e_cyc, e_stb, e_we, e_sgn, e_siz, e_adr, e_dat} =
               {dcyc_i, dstb_i, dwe_i, dsigned_i, dsiz_i, dadr_i, ddat_i};
         end
         e_exp  = e_stb && !back_i && (wt == TO);
         e_iack = (own == 1) && istb_i && (back_i || e_exp);
         e_dack = (own == 2) && dstb_i && (back_i || e_exp);
         e_idat = ((own == 1) && istb_i && back_i) ? bdat_i[31:0] : 32'h0;
         e_ddat = ((own == 2) && dstb_i && back_i) ? bdat_i : 64'h0;
         checks++;
         if (gnt_o !== 2'(own)) begin
            errors++;
            $display("FAIL rand%0d_gnt: got %b want %0d", n, gnt_o, own);
         end
         checks++;
         if ({bcyc_o, bstb_o, bwe_o, bsigned_o, bsiz_o, badr_o, bdat_o} !==
             {e_cyc, e_stb, e_we, e_sgn, e_siz, e_adr, e_dat}) begin
            errors++;
            $display("FAIL rand%0d_bus: got cyc=%b stb=%b we=%b sgn=%b siz=%b adr=%h dat=%h want %b%b%b%b/%b/%h/%h",
                     n, bcyc_o, bstb_o, bwe_o, bsigned_o, bsiz_o, badr_o, bdat_o,
                     e_cyc, e_stb, e_we, e_sgn, e_siz, e_adr, e_dat);
         end
         checks++;
         if ({iack_o, dack_o, timeout_o} !== {e_iack, e_dack, e_exp}) begin
            errors++;
            $display("FAIL rand%0d_ack: got iack=%b dack=%b timeout=%b want %b/%b/%b (wait=%0d)",
                     n, iack_o, dack_o, timeout_o, e_iack, e_dack, e_exp, wt);
         end
         checks++;
         if ({idat_o, ddat_o} !== {e_idat, e_ddat}) begin
            errors++;
            $display("FAIL rand%0d_data: got idat=%h ddat=%h want %h/%h", n, idat_o, ddat_o, e_idat, e_ddat);
         end
         case (own)
            1:       nown = (e_iack || !istb_i) ? arbitrate(dcyc_i, istb_i) : 1;
            2:       nown = dcyc_i ? 2 : arbitrate(1'b0, istb_i);
            default: nown = arbitrate(dcyc_i, istb_i);
         endcase
         if ((nown != own) || e_iack || e_dack || !e_stb) wt = 0;
         else if (wt < TO) wt = wt + 1;
         tick();
         own = nown;
      end
      idle_all();
   endtask

   initial begin
      reset_i = 0;
      test_reset();
      test_ifetch();
      test_simultaneous();
      test_locked_burst();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
